// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter2
// Purpose  : Two-master Wishbone arbiter sharing one slave port between the
//            CPU (master 0) and a second bus master (master 1, DMA / loader).
//            Round-robin grant on ties, grant held for the whole cyc, and a
//            watchdog that force-terminates strobes the slave never acks.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i, rst_i           system clock, synchronous active-high reset
//   m0_* / m1_*            master-side Wishbone (adr 20b, dat 16b, we, byte,
//                          stb, cyc in; dat 16b, ack out)
//   s_*                    slave-side Wishbone towards the memory map
//   gnt_o                  one-hot current grant (bit0 = m0, bit1 = m1)
//   timeout_o              sticky flag, set on any forced termination
// ============================================================================
module wb_arbiter2 #(
    parameter int TIMEOUT = 255,    // unacked strobe cycles before forced end
    parameter int TO_W    = 16      // watchdog width, must hold TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_i,

    // master 0 (CPU)
    input  logic [19:0] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    output logic [15:0] m0_dat_o,
    input  logic        m0_we_i,
    input  logic        m0_byte_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic        m0_ack_o,

    // master 1 (DMA / debug loader)
    input  logic [19:0] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    output logic [15:0] m1_dat_o,
    input  logic        m1_we_i,
    input  logic        m1_byte_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic        m1_ack_o,

    // shared slave port
    output logic [19:0] s_adr_o,
    output logic [15:0] s_dat_o,
    input  logic [15:0] s_dat_i,
    output logic        s_we_o,
    output logic        s_byte_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic        s_ack_i,

    // status
    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] c_TIMEOUT_CNT = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] c_WDOG_ONE    = TO_W'(1);
    localparam logic [15:0]     c_TERM_DATA   = 16'hFFFF;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic            last_q,  last_d;      // last master served (0 / 1)
    logic [TO_W-1:0] wdog_q,  wdog_d;      // consecutive unacked strobes
    logic            timeout_q, timeout_d;

    // ------------------------------------------------------------------------
    // Granted master's handshake signals
    // ------------------------------------------------------------------------
    logic w_cyc;
    logic w_stb;
    logic w_term;   // forced-termination cycle

    always_comb begin
        w_cyc = 1'b0;
        w_stb = 1'b0;
        case (state_q)
            GNT0: begin
                w_cyc = m0_cyc_i;
                w_stb = m0_stb_i;
            end
            GNT1: begin
                w_cyc = m1_cyc_i;
                w_stb = m1_stb_i;
            end
            default: begin
                w_cyc = 1'b0;
                w_stb = 1'b0;
            end
        endcase
    end

    // The watchdog value is registered, so reaching TIMEOUT at a clock edge
    // makes the following cycle the termination cycle. An ack in the cycle
    // that would have made the counter reach TIMEOUT clears it instead, so
    // the normal ack wins that race.
    assign w_term = (state_q != IDLE) && (wdog_q == c_TIMEOUT_CNT);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        wdog_d    = '0;
        timeout_d = timeout_q | w_term;

        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    // tie: favour whoever was not served last
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Count only while the grant is kept and a strobe is waiting; any
        // ack, idle strobe, grant release or termination restarts at zero.
        if (w_cyc && w_stb && !s_ack_i && !w_term) begin
            wdog_d = wdog_q + c_WDOG_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;   // makes master 0 win the first tie
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    // ------------------------------------------------------------------------
    // Bus multiplexing: the granted master sees the slave combinationally,
    // the other master sees ack=0 and dat=0. Everything is zero in IDLE.
    // ------------------------------------------------------------------------
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_byte_o = 1'b0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        gnt_o    = 2'b00;

        case (state_q)
            GNT0: begin
                gnt_o    = 2'b01;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_byte_o = m0_byte_i;
                s_cyc_o  = m0_cyc_i;
                // strobe withdrawn and a late slave ack masked while the
                // master is handed the error pattern
                s_stb_o  = m0_stb_i & ~w_term;
                m0_ack_o = w_term | s_ack_i;
                m0_dat_o = w_term ? c_TERM_DATA : s_dat_i;
            end
            GNT1: begin
                gnt_o    = 2'b10;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_byte_o = m1_byte_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~w_term;
                m1_ack_o = w_term | s_ack_i;
                m1_dat_o = w_term ? c_TERM_DATA : s_dat_i;
            end
            default: begin
                gnt_o    = 2'b00;
            end
        endcase
    end

    // Visible already in the termination cycle, then held by the register.
    assign timeout_o = timeout_q | w_term;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter2
// Purpose  : Self-checking bench for wb_arbiter2 (TIMEOUT = 4). Expected
//            acknowledges are queued when a transfer is issued and compared
//            by a monitor whenever either master is acknowledged.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter2;

    logic        clk;
    logic        rst_i;
    logic [19:0] m0_adr_i, m1_adr_i;
    logic [15:0] m0_dat_i, m1_dat_i;
    logic [15:0] m0_dat_o, m1_dat_o;
    logic        m0_we_i, m1_we_i, m0_byte_i, m1_byte_i;
    logic        m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i;
    logic        m0_ack_o, m1_ack_o;
    logic [19:0] s_adr_o;
    logic [15:0] s_dat_o;
    logic [15:0] s_dat_i;
    logic        s_we_o, s_byte_o, s_stb_o, s_cyc_o;
    logic        s_ack_i;
    logic [1:0]  gnt_o;
    logic        timeout_o;

    int n_pass  = 0;
    int n_total = 0;

    // scoreboard entry: {acked master id, expected dat_o}
    logic [16:0] sb_q[$];
    logic [16:0] mon_exp, mon_got;

    // slave model controls (8'hFF = never ack)
    logic [7:0]  sl_delay;
    logic [15:0] sl_rdata;
    logic [7:0]  sl_wcnt;

    wb_arbiter2 #(.TIMEOUT(4), .TO_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_we_i(m0_we_i), .m0_byte_i(m0_byte_i), .m0_stb_i(m0_stb_i),
        .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_we_i(m1_we_i), .m1_byte_i(m1_byte_i), .m1_stb_i(m1_stb_i),
        .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_we_o(s_we_o), .s_byte_o(s_byte_o), .s_stb_o(s_stb_o),
        .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered slave: acks in the (sl_delay+2)-th strobe cycle.
    always @(posedge clk) begin
        if (rst_i || !s_stb_o || s_ack_i) begin
            s_ack_i <= 1'b0;
            sl_wcnt <= 8'd0;
        end else if (sl_delay != 8'hFF && sl_wcnt == sl_delay) begin
            s_ack_i <= 1'b1;
            sl_wcnt <= 8'd0;
        end else begin
            sl_wcnt <= sl_wcnt + 8'd1;
        end
    end
    assign s_dat_i = s_ack_i ? sl_rdata : 16'h0000;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (m0_ack_o || m1_ack_o) begin
            n_total++;
            mon_got = {m1_ack_o, (m1_ack_o ? m1_dat_o : m0_dat_o)};
            if (m0_ack_o && m1_ack_o) begin
                $display("FAIL sb_ack: both acks high at %0t, required one", $time);
            end else if (sb_q.size() == 0) begin
                $display("FAIL sb_ack: unexpected ack {id,dat}=%h at %0t, required none", mon_got, $time);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_got !== mon_exp) $display("FAIL sb_ack: got {id,dat}=%h, required %h at %0t", mon_got, mon_exp, $time);
                else n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [19:0] adr, input logic [15:0] dat);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
        end
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic wait_ack(input int m);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ack_o : m1_ack_o) seen = 1'b1;
        end
        if (!seen) begin
            n_total++;
            $display("FAIL wait_ack_m%0d: ack 0, required 1 within 40 cycles", m);
        end
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_i = 1'b1;
        drive_m(0, 1'b1, 1'b1, 1'b1, 20'hABCDE, 16'h5555);
        drive_m(1, 1'b1, 1'b1, 1'b1, 20'h12345, 16'hAAAA);
        m0_byte_i = 1'b1; m1_byte_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (gnt_o !== 2'b00) $display("FAIL rst_gnt: gnt_o=%b, required 00", gnt_o);
        else n_pass++;
        n_total++;
        if ({s_adr_o, s_dat_o, s_we_o, s_byte_o, s_stb_o, s_cyc_o} !== 40'h0)
            $display("FAIL rst_slave: slave bus=%h, required 0", {s_adr_o, s_dat_o, s_we_o, s_byte_o, s_stb_o, s_cyc_o});
        else n_pass++;
        n_total++;
        if ({m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o} !== 34'h0)
            $display("FAIL rst_master: acks/dat=%h, required 0", {m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o});
        else n_pass++;
        n_total++;
        if (timeout_o !== 1'b0) $display("FAIL rst_timeout: timeout_o=%b, required 0", timeout_o);
        else n_pass++;
        step();
        rst_i = 1'b0;
        drive_m(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        drive_m(1, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        m0_byte_i = 1'b0; m1_byte_i = 1'b0;
        step();
    endtask

    task automatic test_m0_read();
        sl_delay = 8'd1;
        sl_rdata = 16'h1234;
        drive_m(0, 1'b1, 1'b1, 1'b0, 20'hF0000, 16'h0);
        sb_q.push_back({1'b0, 16'h1234});
        @(negedge clk);
        n_total++;
        if (gnt_o !== 2'b00) $display("FAIL m0rd_latency: gnt_o=%b, required 00", gnt_o);
        else n_pass++;
        step();
        @(negedge clk);
        n_total++;
        if ({gnt_o, s_adr_o, s_stb_o, s_cyc_o, s_we_o} !== {2'b01, 20'hF0000, 1'b1, 1'b1, 1'b0})
            $display("FAIL m0rd_grant: gnt=%b adr=%h stb=%b cyc=%b we=%b, required 01 F0000 1 1 0",
                     gnt_o, s_adr_o, s_stb_o, s_cyc_o, s_we_o);
        else n_pass++;
        wait_ack(0);
        n_total++;
        if ({m1_ack_o, m1_dat_o} !== 17'h0) $display("FAIL m0rd_other: m1 ack/dat=%h, required 0", {m1_ack_o, m1_dat_o});
        else n_pass++;
        step();
        drive_m(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        step();
        @(negedge clk);
        n_total++;
        if ({gnt_o, s_cyc_o} !== 3'b000) $display("FAIL m0rd_release: gnt=%b cyc=%b, required 00 0", gnt_o, s_cyc_o);
        else n_pass++;
        step();
    endtask

    task automatic test_round_robin();
        int w;
        logic [15:0] d;
        logic [1:0] eg;
        drive_m(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        drive_m(1, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        apply_reset();
        sl_delay = 8'd0;
        drive_m(0, 1'b1, 1'b1, 1'b0, 20'h10000, 16'h0);
        drive_m(1, 1'b1, 1'b1, 1'b0, 20'h20000, 16'h0);
        w = 0;
        for (int r = 0; r < 4; r++) begin
            d = 16'hA000 + 16'(r);
            eg = (w == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_total++;
            if (gnt_o !== 2'b00) $display("FAIL rr_idle%0d: gnt_o=%b, required 00", r, gnt_o);
            else n_pass++;
            sl_rdata = d;
            sb_q.push_back({w[0], d});
            step();
            @(negedge clk);
            n_total++;
            if (gnt_o !== eg) $display("FAIL rr_grant%0d: gnt_o=%b, required %b", r, gnt_o, eg);
            else n_pass++;
            wait_ack(w);
            step();
            drive_m(w, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
            if (r == 3) drive_m(1 - w, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
            step();
            if (r < 3) drive_m(w, 1'b1, 1'b1, 1'b0, (w == 0) ? 20'h10000 : 20'h20000, 16'h0);
            w = 1 - w;
        end
        step();
    endtask

    task automatic test_locked_cycle();
        logic [19:0] a;
        logic [15:0] d;
        sl_delay = 8'd0;
        sl_rdata = 16'h5A5A;
        drive_m(1, 1'b1, 1'b1, 1'b1, 20'hB8000, 16'h1111);
        step();
        drive_m(0, 1'b1, 1'b1, 1'b0, 20'hF0010, 16'h0);
        for (int k = 0; k < 3; k++) begin
            a = 20'hB8000 + 20'(k);
            d = 16'h1111 + 16'(k);
            sb_q.push_back({1'b1, 16'h5A5A});
            @(negedge clk);
            n_total++;
            if ({gnt_o, s_we_o, s_stb_o, s_adr_o, s_dat_o} !== {2'b10, 1'b1, 1'b1, a, d})
                $display("FAIL lock_bus%0d: gnt=%b we=%b stb=%b adr=%h dat=%h, required 10 1 1 %h %h",
                         k, gnt_o, s_we_o, s_stb_o, s_adr_o, s_dat_o, a, d);
            else n_pass++;
            wait_ack(1);
            step();
            drive_m(1, 1'b1, 1'b0, 1'b1, a, d);
            if (k < 2) begin
                step();
                drive_m(1, 1'b1, 1'b1, 1'b1, a + 20'd1, d + 16'd1);
            end
        end
        step();
        drive_m(1, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        @(negedge clk);
        n_total++;
        if (gnt_o !== 2'b10) $display("FAIL lock_hold: gnt_o=%b, required 10", gnt_o);
        else n_pass++;
        sl_rdata = 16'h7777;
        sb_q.push_back({1'b0, 16'h7777});
        step();
        @(negedge clk);
        n_total++;
        if (gnt_o !== 2'b00) $display("FAIL lock_idle: gnt_o=%b, required 00", gnt_o);
        else n_pass++;
        step();
        @(negedge clk);
        n_total++;
        if ({gnt_o, s_adr_o} !== {2'b01, 20'hF0010}) $display("FAIL lock_m0_grant: gnt=%b adr=%h, required 01 F0010", gnt_o, s_adr_o);
        else n_pass++;
        wait_ack(0);
        step();
        drive_m(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        step();
        step();
    endtask

    task automatic test_timeout(input logic [7:0] delay, input logic [15:0] rdata, input string tag);
        int bad;
        sl_delay = delay;
        sl_rdata = rdata;
        drive_m(0, 1'b1, 1'b1, 1'b0, 20'h12345, 16'h0);
        sb_q.push_back({1'b0, 16'hFFFF});
        step();
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!(s_stb_o === 1'b1 && m0_ack_o === 1'b0)) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL %s_wait: %0d bad strobe cycles, required 0", tag, bad);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({s_stb_o, m0_ack_o, m0_dat_o, timeout_o} !== {1'b0, 1'b1, 16'hFFFF, 1'b1})
            $display("FAIL %s_term: stb=%b ack=%b dat=%h timeout=%b, required 0 1 ffff 1",
                     tag, s_stb_o, m0_ack_o, m0_dat_o, timeout_o);
        else n_pass++;
        if (delay != 8'hFF) begin
            n_total++;
            if (s_ack_i !== 1'b1) $display("FAIL %s_lateack: s_ack_i=%b, required 1", tag, s_ack_i);
            else n_pass++;
        end
        step();
        drive_m(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        @(negedge clk);
        n_total++;
        if (m0_ack_o !== 1'b0) $display("FAIL %s_onecycle: m0_ack_o=%b, required 0", tag, m0_ack_o);
        else n_pass++;
        step();
        step();
        @(negedge clk);
        n_total++;
        if ({gnt_o, timeout_o} !== 3'b001) $display("FAIL %s_sticky: gnt=%b timeout=%b, required 00 1", tag, gnt_o, timeout_o);
        else n_pass++;
        step();
    endtask

    task automatic test_ack_at_limit();
        apply_reset();
        sl_delay = 8'd2;
        sl_rdata = 16'hC0DE;
        drive_m(0, 1'b1, 1'b1, 1'b0, 20'h00400, 16'h0);
        sb_q.push_back({1'b0, 16'hC0DE});
        step();
        repeat (3) @(negedge clk);
        @(negedge clk);
        n_total++;
        if ({m0_ack_o, m0_dat_o, timeout_o} !== {1'b1, 16'hC0DE, 1'b0})
            $display("FAIL limit_ack: ack=%b dat=%h timeout=%b, required 1 c0de 0", m0_ack_o, m0_dat_o, timeout_o);
        else n_pass++;
        step();
        drive_m(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        @(negedge clk);
        n_total++;
        if ({m0_ack_o, timeout_o} !== 2'b00) $display("FAIL limit_noterm: ack=%b timeout=%b, required 0 0", m0_ack_o, timeout_o);
        else n_pass++;
        step();
        step();
        @(negedge clk);
        n_total++;
        if (timeout_o !== 1'b0) $display("FAIL limit_flag: timeout_o=%b, required 0", timeout_o);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_access();
        sl_delay = 8'hFF;
        drive_m(1, 1'b1, 1'b1, 1'b1, 20'hB8100, 16'hCAFE);
        step();
        @(negedge clk);
        n_total++;
        if (gnt_o !== 2'b10) $display("FAIL rstmid_grant: gnt_o=%b, required 10", gnt_o);
        else n_pass++;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        drive_m(0, 1'b1, 1'b1, 1'b0, 20'hF0020, 16'h0);
        @(negedge clk);
        n_total++;
        if ({gnt_o, s_stb_o, m1_ack_o} !== 4'b0000) $display("FAIL rstmid_abort: gnt=%b stb=%b m1_ack=%b, required 00 0 0", gnt_o, s_stb_o, m1_ack_o);
        else n_pass++;
        sl_delay = 8'd0;
        sl_rdata = 16'h4242;
        sb_q.push_back({1'b0, 16'h4242});
        step();
        @(negedge clk);
        n_total++;
        if (gnt_o !== 2'b01) $display("FAIL rstmid_tie: gnt_o=%b, required 01", gnt_o);
        else n_pass++;
        wait_ack(0);
        step();
        drive_m(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        drive_m(1, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        step();
        step();
    endtask

    initial begin
        rst_i     = 1'b1;
        sl_delay  = 8'hFF;
        sl_rdata  = 16'h0;
        m0_byte_i = 1'b0;
        m1_byte_i = 1'b0;
        drive_m(0, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        drive_m(1, 1'b0, 1'b0, 1'b0, 20'h0, 16'h0);

        test_reset();
        test_m0_read();
        test_round_robin();
        test_locked_cycle();
        test_timeout(8'hFF, 16'h0000, "to_noack");
        test_timeout(8'd3,  16'hBEEF, "to_late");
        test_ack_at_limit();
        test_reset_mid_access();

        n_total++;
        if (sb_q.size() != 0) $display("FAIL sb_drain: %0d acks outstanding, required 0", sb_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
Two-master Wishbone arbiter that shares the single memory/VDU Wishbone port between the CPU (master 0) and a second bus master (master 1, e.g. DMA or debug loader). It sits in front of the address-decoding memory map. It grants the bus round-robin and holds each grant for a whole cycle (cyc high). A watchdog terminates any access the slave fails to acknowledge.

Parameters:
TIMEOUT, 255, consecutive unacknowledged strobe cycles before the arbiter forces termination (range 2..65535).
TO_W, 16, width of the watchdog counter; TO_W bits must hold TIMEOUT.

Ports:
clk_i  in  1  system clock (25 MHz)
rst_i  in  1  reset; synchronous, active-high
m0_adr_i  in  20  master 0 address
m0_dat_i  in  16  master 0 write data
m0_dat_o  out  16  master 0 read data
m0_we_i  in  1  master 0 write enable
m0_byte_i  in  1  master 0 byte access
m0_stb_i  in  1  master 0 strobe
m0_cyc_i  in  1  master 0 cycle
m0_ack_o  out  1  master 0 acknowledge
m1_adr_i, m1_dat_i, m1_dat_o, m1_we_i, m1_byte_i, m1_stb_i, m1_cyc_i, m1_ack_o: same widths and meaning for master 1
s_adr_o  out  20  slave address
s_dat_o  out  16  slave write data
s_dat_i  in  16  slave read data
s_we_o  out  1  slave write enable
s_byte_o  out  1  slave byte access
s_stb_o  out  1  slave strobe
s_cyc_o  out  1  slave cycle
s_ack_i  in  1  slave acknowledge
gnt_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1)
timeout_o  out  1  sticky flag, set on any forced termination

Behaviour:
- Reset (rst_i sampled high at a clock edge): state=IDLE, last-served pointer=1, watchdog=0, timeout_o=0. All outputs go low/zero: gnt_o=0, s_stb_o=0, s_cyc_o=0, s_we_o=0, s_byte_o=0, s_adr_o=0, s_dat_o=0, m0_ack_o=0, m1_ack_o=0, m0_dat_o=0, m1_dat_o=0. Reset mid-access abandons the access with no ack to either master.
- States: IDLE, GNT0, GNT1. gnt_o decodes the state as 00 / 01 / 10.
- IDLE transitions:
  - Only m0_cyc_i high -> GNT0.
  - Only m1_cyc_i high -> GNT1.
  - Both high -> grant the master not equal to last-served. After reset, master 0 wins the first tie.
  - Neither high -> stay in IDLE.
  - Grant takes effect on the next cycle: request latency is 1 clock minimum.
- GNTx:
  - Slave outputs (adr, dat, we, byte, stb, cyc) are combinational copies of master x's inputs.
  - s_ack_i routes combinationally to mx_ack_o. s_dat_i routes to mx_dat_o.
  - The other master sees ack=0 and dat_o=0.
  - Grant is held while mx_cyc_i is high, including across multiple stb pulses (locked transfer).
  - When mx_cyc_i is sampled low: go to IDLE and set last-served=x. There is always one IDLE cycle between grants.
- In IDLE, all slave outputs are zero and both acks are 0.
- Watchdog:
  - Counter increments each cycle in GNTx with mx_stb_i=1 and s_ack_i=0.
  - Counter clears on s_ack_i=1, on mx_stb_i=0, and on state change.
  - When counter == TIMEOUT, the next cycle is a forced-termination cycle:
    - s_stb_o=0
    - mx_ack_o=1 for exactly 1 cycle
    - mx_dat_o=16'hFFFF
    - timeout_o set; it stays set until reset
    - counter cleared
  - A late s_ack_i arriving during the forced-termination cycle is ignored.
- Simultaneous events:
  - mx_cyc_i dropping in the same cycle the other master raises cyc: IDLE is entered first, then the other master is granted.
  - s_ack_i arriving in the cycle the counter reaches TIMEOUT: the normal ack wins, and no forced termination occurs.
- Byte/data widths pass through unmodified. The arbiter does no address decoding.

Test Plan:
- Reset, then m0 only: m0 read at 20'hF0000 with slave acking after 2 cycles -> gnt_o=01 one cycle after cyc, m0_ack_o pulses with s_dat_i=16'h1234 on m0_dat_o, m1_ack_o stays 0.
- Both cyc high in the same IDLE cycle, repeated 4 times -> grants alternate m0, m1, m0, m1, each separated by one IDLE cycle with gnt_o=00.
- Locked cycle: m1 holds cyc for 3 stb/ack writes to 20'hB8000 while m0 requests -> m0 is not granted until the cycle after m1_cyc_i falls, and m0_ack_o=0 throughout.
- Slave never acks a m0 read, TIMEOUT=4 -> after 4 stb cycles, s_stb_o drops, m0_ack_o=1 for 1 cycle with m0_dat_o=16'hFFFF, timeout_o=1 and stays 1.
- s_ack_i asserted exactly when the counter reaches TIMEOUT -> normal ack with slave data, timeout_o stays 0.
- rst_i asserted during a granted m1 write awaiting ack -> next cycle gnt_o=00, s_stb_o=0, no ack to m1, pointer reset so a following tie grants m0.
